// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
`include "sub_defs.vh"

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = `SUB_ST_IDLE,
        SHIFT = `SUB_ST_SHIFT,
        DONE  = `SUB_ST_DONE
    } state_e;

endpackage

// File: rtl/half_subtractor.sv
// Gate-level half subtractor: diff = a^b, borrow_out = ~a&b.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow_out
);

    logic a_n;

    not u_not (a_n, a);
    xor u_xor (diff, a, b);
    and u_and (borrow_out, a_n, b);

endmodule

// File: rtl/sub_defs.vh
// State encodings for the serial subtractor FSM.
`ifndef SUB_DEFS_VH
`define SUB_DEFS_VH
`define SUB_ST_IDLE  2'b00
`define SUB_ST_SHIFT 2'b01
`define SUB_ST_DONE  2'b10
`endif

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle, LSB first, registered result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic hs1_d, hs1_b;
    logic bit_d, hs2_b;
    logic br_next;

    // Two cascaded half subtractors form the full-subtract bit cell.
    half_subtractor u_hs1 (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .diff       (hs1_d),
        .borrow_out (hs1_b)
    );

    half_subtractor u_hs2 (
        .a          (hs1_d),
        .b          (br_q),
        .diff       (bit_d),
        .borrow_out (hs2_b)
    );

    assign br_next = hs1_b | hs2_b;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                br_d  = br_next;
                if (cnt_q == LAST) begin
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);

endmodule
